fg_timing_generator: RTL and testbench

- Synthesizable source of the fast-gate timing pair consumed by the synchronization FSM: periodic fg_signal gate pulse, plus a delayed fg_open acquisition window.
- Drives the FSM's fg_signal input on hardware test rigs and in closed-loop simulation; replaces behavioural delay-based stimulus.
- Runs bursts of N gate periods, or runs continuously; reports progress and completion.

---
 rtl/fg_timing_generator.sv | 139 +++++++++++++
 tb/tb_fg_timing_generator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fg_timing_generator.sv
// Fast-gate timing source: periodic fg_signal gate pulse plus a delayed fg_open window,
// run in bursts of burst_len periods or continuously, with graceful stop on enable low.
module fg_timing_generator #(
    parameter int unsigned PERIOD_CYCLES     = 2_000_000,
    parameter int unsigned GATE_CYCLES       = 20_000,
    parameter int unsigned OPEN_DELAY_CYCLES = 400_000,
    parameter int unsigned OPEN_CYCLES       = 20_000,
    parameter int unsigned BURST_W           = 16,
    parameter int unsigned CNT_W             = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               fg_signal,
    output logic               fg_open,
    output logic               busy,
    output logic [BURST_W-1:0] period_idx,
    output logic [CNT_W-1:0]   gate_count,
    output logic               done
);

    if (PERIOD_CYCLES == 0 || GATE_CYCLES == 0 || OPEN_DELAY_CYCLES == 0 || OPEN_CYCLES == 0)
    begin : g_bad_zero
        $fatal(1, "fg_timing_generator: all cycle parameters must be >= 1");
    end
    if (GATE_CYCLES >= PERIOD_CYCLES) begin : g_bad_gate
        $fatal(1, "fg_timing_generator: GATE_CYCLES must be < PERIOD_CYCLES");
    end
    if (OPEN_DELAY_CYCLES + OPEN_CYCLES > PERIOD_CYCLES) begin : g_bad_open
        $fatal(1, "fg_timing_generator: open window must fit inside one period");
    end

    localparam int unsigned PH_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PERIOD_CYCLES - 1);
    localparam int unsigned OPEN_END = OPEN_DELAY_CYCLES + OPEN_CYCLES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] period_q, period_d;
    logic [CNT_W-1:0]   gate_q, gate_d;
    logic               fg_signal_q, fg_signal_d;
    logic               fg_open_q, fg_open_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        phase_ext;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        period_d = period_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (start && enable) begin
                    state_d  = ST_RUN;
                    len_d    = burst_len;
                    period_d = '0;
                end
            end
            ST_RUN, ST_STOP: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d  = '0;
                    period_d = period_q + 1'b1;
                    // Enable low on the final phase ends the run here rather than
                    // committing to another full period in STOP.
                    if (state_q == ST_STOP || !enable ||
                        (len_q != '0 && period_d == len_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (state_q == ST_RUN && !enable) begin
                        state_d = ST_STOP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so the gate rises the cycle after start.
    assign phase_ext = 32'(phase_d);

    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        fg_signal_d = busy_d && (phase_ext < GATE_CYCLES);
        fg_open_d   = busy_d && (phase_ext >= OPEN_DELAY_CYCLES) && (phase_ext < OPEN_END);
        gate_d      = gate_q;
        if (busy_d && phase_d == '0) begin
            gate_d = gate_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            len_q       <= '0;
            period_q    <= '0;
            gate_q      <= '0;
            fg_signal_q <= 1'b0;
            fg_open_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            len_q       <= len_d;
            period_q    <= period_d;
            gate_q      <= gate_d;
            fg_signal_q <= fg_signal_d;
            fg_open_q   <= fg_open_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fg_signal  = fg_signal_q;
    assign fg_open    = fg_open_q;
    assign busy       = busy_q;
    assign period_idx = period_q;
    assign gate_count = gate_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fg_timing_generator.sv
// Directed bench for fg_timing_generator: table of burst scenarios checked every cycle,
// plus hand-written reset-state, reset-mid-burst and re-enable-in-STOP sequences.
module tb_fg_timing_generator;

    localparam int unsigned PERIOD = 20;
    localparam int unsigned GATE   = 4;
    localparam int unsigned DELAY  = 8;
    localparam int unsigned OPEN   = 3;
    localparam int unsigned BW     = 16;
    localparam int unsigned CW     = 32;
    localparam logic [7:0]  NA     = 8'hFF;
    localparam logic [7:0]  Z      = 8'h00;

    logic          clock = 1'b0;
    logic          reset, enable, start;
    logic [BW-1:0] burst_len;
    logic          fg_signal, fg_open, busy, done;
    logic [BW-1:0] period_idx;
    logic [CW-1:0] gate_count;

    int tests = 0;
    int fails = 0;
    int hc;

    always #5 clock = ~clock;

    fg_timing_generator #(
        .PERIOD_CYCLES     (PERIOD),
        .GATE_CYCLES       (GATE),
        .OPEN_DELAY_CYCLES (DELAY),
        .OPEN_CYCLES       (OPEN),
        .BURST_W           (BW),
        .CNT_W             (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .burst_len  (burst_len),
        .fg_signal  (fg_signal),
        .fg_open    (fg_open),
        .busy       (busy),
        .period_idx (period_idx),
        .gate_count (gate_count),
        .done       (done)
    );

    typedef logic [2:0][7:0] rng3_t;
    typedef logic [1:0][7:0] rng2_t;

    // Ranges are inclusive [lo, hi]; an unused slot has lo=NA, hi=0 and so is empty.
    typedef struct {
        logic [15:0] len1;
        logic [7:0]  st1;
        logic [15:0] len2;
        logic [7:0]  st2;
        logic [7:0]  en_on;
        logic [7:0]  en_off;
        logic [7:0]  rst_at;
        logic [7:0]  last;
        rng3_t       sig_lo;
        rng3_t       sig_hi;
        rng3_t       opn_lo;
        rng3_t       opn_hi;
        rng2_t       bsy_lo;
        rng2_t       bsy_hi;
        rng2_t       dn;
        logic [15:0] exp_pidx;
        logic [31:0] exp_gates;
    } vec_t;

    vec_t vecs[7];

    function automatic bit in3(input int c, input rng3_t lo, input rng3_t hi);
        for (int k = 0; k < 3; k++) begin
            if (c >= int'(lo[k]) && c <= int'(hi[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit in2(input int c, input rng2_t lo, input rng2_t hi);
        for (int k = 0; k < 2; k++) begin
            if (c >= int'(lo[k]) && c <= int'(hi[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", what, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        hc++;
    endtask

    // Per-cycle compare of {fg_signal, fg_open, busy, done}.
    task automatic run_vec(input int i);
        vec_t v;
        logic [3:0] exp;
        v = vecs[i];
        for (int c = 0; c <= int'(v.last); c++) begin
            if (c >= 1) begin
                exp = {in3(c, v.sig_lo, v.sig_hi), in3(c, v.opn_lo, v.opn_hi),
                       in2(c, v.bsy_lo, v.bsy_hi),
                       (c == int'(v.dn[0]) || c == int'(v.dn[1]))};
                check($sformatf("vec%0d cyc%0d {sig,open,busy,done}", i, c),
                      {28'd0, fg_signal, fg_open, busy, done}, {28'd0, exp});
            end
            reset     = (c < 2) || (c == int'(v.rst_at));
            enable    = (c >= int'(v.en_on)) && (c < int'(v.en_off));
            start     = (c == int'(v.st1)) || (c == int'(v.st2));
            burst_len = (c == int'(v.st2)) ? v.len2 : v.len1;
            tick();
        end
        check($sformatf("vec%0d final period_idx", i), {16'd0, period_idx}, {16'd0, v.exp_pidx});
        check($sformatf("vec%0d final gate_count", i), gate_count, v.exp_gates);
    endtask

    task automatic run_to(input int target);
        while (hc < target) tick();
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        hc        = 0;

        // Burst of 3
        vecs[0] = '{16'd3, 8'd10, 16'd0, NA, 8'd2, NA, NA, 8'd75,
                    '{8'd11, 8'd31, 8'd51}, '{8'd14, 8'd34, 8'd54},
                    '{8'd19, 8'd39, 8'd59}, '{8'd21, 8'd41, 8'd61},
                    '{8'd11, NA}, '{8'd70, Z}, '{8'd71, NA}, 16'd3, 32'd3};
        // Continuous, graceful stop at 45
        vecs[1] = '{16'd0, 8'd10, 16'd0, NA, 8'd2, 8'd45, NA, 8'd55,
                    '{8'd11, 8'd31, NA}, '{8'd14, 8'd34, Z},
                    '{8'd19, 8'd39, NA}, '{8'd21, 8'd41, Z},
                    '{8'd11, NA}, '{8'd50, Z}, '{8'd51, NA}, 16'd2, 32'd2};
        // Reset at 40 mid-burst, new start at 45
        vecs[2] = '{16'd5, 8'd10, 16'd5, 8'd45, 8'd2, NA, 8'd40, 8'd60,
                    '{8'd11, 8'd31, 8'd46}, '{8'd14, 8'd34, 8'd49},
                    '{8'd19, 8'd39, 8'd54}, '{8'd21, 8'd40, 8'd56},
                    '{8'd11, 8'd46}, '{8'd40, 8'd60}, '{NA, NA}, 16'd0, 32'd1};
        // Start with enable low is ignored
        vecs[3] = '{16'd3, 8'd5, 16'd0, NA, NA, NA, NA, 8'd15,
                    '{NA, NA, NA}, '{Z, Z, Z}, '{NA, NA, NA}, '{Z, Z, Z},
                    '{NA, NA}, '{Z, Z}, '{NA, NA}, 16'd0, 32'd0};
        // Start at 15 with len 9 during a 2-period burst is ignored
        vecs[4] = '{16'd2, 8'd10, 16'd9, 8'd15, 8'd2, NA, NA, 8'd55,
                    '{8'd11, 8'd31, NA}, '{8'd14, 8'd34, Z},
                    '{8'd19, 8'd39, NA}, '{8'd21, 8'd41, Z},
                    '{8'd11, NA}, '{8'd50, Z}, '{8'd51, NA}, 16'd2, 32'd2};
        // Back-to-back single-period bursts, second start in done cycle
        vecs[5] = '{16'd1, 8'd10, 16'd1, 8'd31, 8'd2, NA, NA, 8'd56,
                    '{8'd11, 8'd32, NA}, '{8'd14, 8'd35, Z},
                    '{8'd19, 8'd40, NA}, '{8'd21, 8'd42, Z},
                    '{8'd11, 8'd32}, '{8'd30, 8'd51}, '{8'd31, 8'd52}, 16'd1, 32'd2};
        // Enable drops on the last phase of the final period
        vecs[6] = '{16'd2, 8'd10, 16'd0, NA, 8'd2, 8'd50, NA, 8'd55,
                    '{8'd11, 8'd31, NA}, '{8'd14, 8'd34, Z},
                    '{8'd19, 8'd39, NA}, '{8'd21, 8'd41, Z},
                    '{8'd11, NA}, '{8'd50, Z}, '{8'd51, NA}, 16'd2, 32'd2};

        // Reset state
        tick();
        tick();
        check("reset fg_signal", {31'd0, fg_signal}, 32'd0);
        check("reset fg_open", {31'd0, fg_open}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset period_idx", {16'd0, period_idx}, 32'd0);
        check("reset gate_count", gate_count, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset mid-burst clears counters and suppresses done
        hc = 0;
        reset = 1'b1; enable = 1'b0; start = 1'b0; burst_len = '0;
        tick();
        tick();
        reset = 1'b0; enable = 1'b1;
        run_to(10);
        start = 1'b1; burst_len = 16'd5;
        tick();
        start = 1'b0;
        run_to(40);
        check("pre-reset gate_count", gate_count, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset outputs", {28'd0, fg_signal, fg_open, busy, done}, 32'd0);
        check("post-reset gate_count", gate_count, 32'd0);
        check("post-reset period_idx", {16'd0, period_idx}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("post-reset idle cyc%0d", hc), {30'd0, busy, done}, 32'd0);
        end

        // Re-asserting enable in STOP does not resume the run
        hc = 0;
        reset = 1'b1; enable = 1'b0; start = 1'b0; burst_len = '0;
        tick();
        tick();
        reset = 1'b0; enable = 1'b1;
        run_to(10);
        start = 1'b1; burst_len = 16'd0;
        tick();
        start = 1'b0;
        run_to(45);
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        run_to(50);
        check("stop cyc50 {busy,done}", {30'd0, busy, done}, 32'd2);
        tick();
        check("stop cyc51 {sig,busy,done}", {29'd0, fg_signal, busy, done}, 32'd1);
        check("stop period_idx", {16'd0, period_idx}, 32'd2);
        check("stop gate_count", gate_count, 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stop idle cyc%0d {sig,busy,done}", hc),
                  {29'd0, fg_signal, busy, done}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
